// File: rtl/jtkicker_pkg.sv
// Shared constants and helpers for the Kicker colour mixer.
// PROM map, object transparency code and 3-3-2 palette field layout.
package jtkicker_pkg;

    localparam logic [8:0] CHARLUT_BASE = 9'h000;
    localparam logic [8:0] PAL_BASE     = 9'h100;
    localparam int         PAL_AW       = 5;
    localparam int         CHARLUT_AW   = 8;
    localparam logic [3:0] OBJ_TRANSP   = 4'd0;

    localparam int R_LSB = 0;
    localparam int G_LSB = 3;
    localparam int B_LSB = 6;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    function automatic rgb_t pal_expand(input logic [7:0] p);
        rgb_t       c;
        logic [2:0] r3;
        logic [2:0] g3;
        logic [1:0] b2;
        r3  = p[R_LSB +: 3];
        g3  = p[G_LSB +: 3];
        b2  = p[B_LSB +: 2];
        c.r = {r3, r3[2]};
        c.g = {g3, g3[2]};
        c.b = {b2, b2};
        return c;
    endfunction

    function automatic logic is_charlut(input logic [8:0] a);
        return a[8] == CHARLUT_BASE[8];
    endfunction

    function automatic logic is_pal(input logic [8:0] a);
        return a[8:5] == PAL_BASE[8:5];
    endfunction

endpackage

// File: rtl/jtframe_prom.sv
// Dual-address PROM: synchronous read gated by cen, write on we.
// A read and write to the same address on one edge returns old data.
module jtframe_prom #(
    parameter int dw = 8,
    parameter int aw = 10
) (
    input  logic          clk,
    input  logic          cen,
    input  logic [dw-1:0] data,
    input  logic [aw-1:0] rd_addr,
    input  logic [aw-1:0] wr_addr,
    input  logic          we,
    output logic [dw-1:0] q
);

    logic [dw-1:0] mem [0:(1<<aw)-1];

    always_ff @(posedge clk) begin
        if (cen) q <= mem[rd_addr];
        if (we) mem[wr_addr] <= data;
    end

endmodule

// File: rtl/jtkicker_blank_dly.sv
// pxl_cen-gated delay line for the {LHBL, LVBL} pair.
// Reset loads every tap with 0 so the output starts blanked.
module jtkicker_blank_dly #(
    parameter int DLY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic [1:0] din,
    output logic [1:0] dout
);

    logic [1:0] sr [DLY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DLY; i++) sr[i] <= 2'b00;
        end else if (cen) begin
            sr[0] <= din;
            for (int i = 1; i < DLY; i++) sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[DLY-1];

endmodule

// File: rtl/jtkicker_colmix.sv
// Kicker colour mixer: obj/char priority, char LUT, palette, blanking.
// Optional layer enables via macro KICKER_LAYER_MASK_EN (gfx_en port).
module jtkicker_colmix
    import jtkicker_pkg::*;
#(
    parameter int BLANK_DLY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic [3:0] obj_pxl,
    input  logic [7:0] char_pxl,
`ifdef KICKER_LAYER_MASK_EN
    input  logic [1:0] gfx_en,
`endif
    input  logic [8:0] prog_addr,
    input  logic [7:0] prog_data,
    input  logic       prog_en,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       LHBL_dly,
    output logic       LVBL_dly
);

    logic [3:0]        obj_s1;
    logic [1:0]        gfx_s1;
    logic [3:0]        charlut_q;
    logic [3:0]        obj_eff;
    logic [PAL_AW-1:0] idx;
    logic [7:0]        pal_q;
    rgb_t              rgb_q;
    logic              show;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            obj_s1 <= 4'd0;
        end else if (pxl_cen) begin
            obj_s1 <= obj_pxl;
        end
    end

`ifdef KICKER_LAYER_MASK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gfx_s1 <= 2'b00;
        end else if (pxl_cen) begin
            gfx_s1 <= gfx_en;
        end
    end
`else
    assign gfx_s1 = 2'b11;
`endif

    jtframe_prom #(.dw(4), .aw(CHARLUT_AW)) u_charlut (
        .clk     ( clk                                ),
        .cen     ( pxl_cen                            ),
        .data    ( prog_data[3:0]                     ),
        .rd_addr ( char_pxl                           ),
        .wr_addr ( prog_addr[CHARLUT_AW-1:0]          ),
        .we      ( prog_en & is_charlut(prog_addr)    ),
        .q       ( charlut_q                          )
    );

    // A disabled char layer falls back to palette entry 0.
    always_comb begin
        obj_eff = gfx_s1[1] ? obj_s1 : OBJ_TRANSP;
        idx     = '0;
        if (obj_eff != OBJ_TRANSP) idx = {1'b1, obj_eff};
        else if (gfx_s1[0])        idx = {1'b0, charlut_q};
    end

    jtframe_prom #(.dw(8), .aw(PAL_AW)) u_pal (
        .clk     ( clk                        ),
        .cen     ( pxl_cen                    ),
        .data    ( prog_data                  ),
        .rd_addr ( idx                        ),
        .wr_addr ( prog_addr[PAL_AW-1:0]      ),
        .we      ( prog_en & is_pal(prog_addr) ),
        .q       ( pal_q                      )
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
        end else if (pxl_cen) begin
            rgb_q <= pal_expand(pal_q);
        end
    end

    jtkicker_blank_dly #(.DLY(BLANK_DLY)) u_blank (
        .clk  ( clk                  ),
        .rst  ( rst                  ),
        .cen  ( pxl_cen              ),
        .din  ( {LHBL, LVBL}         ),
        .dout ( {LHBL_dly, LVBL_dly} )
    );

    // Blank taps are aligned with the colour stage, so mask here.
    assign show  = LHBL_dly & LVBL_dly;
    assign red   = show ? rgb_q.r : 4'd0;
    assign green = show ? rgb_q.g : 4'd0;
    assign blue  = show ? rgb_q.b : 4'd0;

endmodule

// File: tb/tb_jtkicker_colmix.sv
// Self-checking bench for jtkicker_colmix against a per-pixel model.
// Define KICKER_LAYER_MASK_EN to also exercise the layer enables.
module tb_jtkicker_colmix;

    logic       clk = 0;
    logic       rst = 1;
    logic       pxl_cen = 0;
    logic       LHBL = 1, LVBL = 1;
    logic [3:0] obj_pxl = 0;
    logic [7:0] char_pxl = 0;
    logic [1:0] gfx = 2'b11;
    logic [8:0] prog_addr = 0;
    logic [7:0] prog_data = 0;
    logic       prog_en = 0;
    logic [3:0] red, green, blue;
    logic       LHBL_dly, LVBL_dly;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    jtkicker_colmix dut (
        .clk       ( clk       ),
        .rst       ( rst       ),
        .pxl_cen   ( pxl_cen   ),
        .LHBL      ( LHBL      ),
        .LVBL      ( LVBL      ),
        .obj_pxl   ( obj_pxl   ),
        .char_pxl  ( char_pxl  ),
`ifdef KICKER_LAYER_MASK_EN
        .gfx_en    ( gfx       ),
`endif
        .prog_addr ( prog_addr ),
        .prog_data ( prog_data ),
        .prog_en   ( prog_en   ),
        .red       ( red       ),
        .green     ( green     ),
        .blue      ( blue      ),
        .LHBL_dly  ( LHBL_dly  ),
        .LVBL_dly  ( LVBL_dly  )
    );

    typedef struct {
        logic       h;
        logic       v;
        logic [4:0] idx;
        logic [7:0] palv;
    } entry_t;

    logic [3:0] charlut_m [256];
    logic [7:0] pal_m [32];
    entry_t     hist [2048];
    int         nt = 0;

    // 3-bit guns scale to 4 bits as 2x + msb; the 2-bit blue gun repeats.
    function automatic logic [11:0] expand(input int p);
        int r, g, b;
        r = p % 8;
        g = (p / 8) % 8;
        b = p / 64;
        return {4'(r * 2 + r / 4), 4'(g * 2 + g / 4), 4'(b * 5)};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check(input string tag);
        logic [13:0] exp_v;
        entry_t      e;
        exp_v = '0;
        if (nt >= 3) begin
            e = hist[nt-3];
            exp_v = {(e.h & e.v) ? expand(int'(e.palv)) : 12'h000, e.h, e.v};
        end
        chk(tag, {2'b00, red, green, blue, LHBL_dly, LVBL_dly}, {2'b00, exp_v});
    endtask

    task automatic step(input logic [3:0] o, input logic [7:0] c, input logic h, input logic v);
        entry_t     e;
        logic [3:0] oe;
        @(negedge clk);
        obj_pxl = o; char_pxl = c; LHBL = h; LVBL = v; pxl_cen = 1;
        oe    = gfx[1] ? o : 4'd0;
        e.h   = h;
        e.v   = v;
        e.idx = (oe != 0) ? {1'b1, oe} : (gfx[0] ? {1'b0, charlut_m[c]} : 5'd0);
        e.palv = 8'h00;
        @(negedge clk);
        pxl_cen = 0;
        hist[nt] = e;
        if (nt >= 1) hist[nt-1].palv = pal_m[hist[nt-1].idx];
        nt++;
        check("tick");
        repeat (6) begin
            @(negedge clk);
            check("hold");
        end
    endtask

    task automatic prog(input logic [8:0] a, input logic [7:0] d);
        @(negedge clk);
        prog_addr = a; prog_data = d; prog_en = 1;
        @(negedge clk);
        prog_en = 0;
        if (a[8] == 1'b0) charlut_m[a[7:0]] = d[3:0];
        else if (a[8:5] == 4'b1000) pal_m[a[4:0]] = d;
        if (!rst) check("prog");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) prog(9'(i), 8'($urandom));
        for (int i = 0; i < 32; i++) prog(9'h100 + 9'(i), 8'($urandom));
        @(negedge clk);
        chk("reset_state", {2'b00, red, green, blue, LHBL_dly, LVBL_dly}, 16'h0);
        rst = 0;

        // priority
        prog(9'h025, 8'h07);
        prog(9'h107, 8'hC5);
        prog(9'h113, 8'h38);
        repeat (3) step(4'h0, 8'h25, 1, 1);
        chk("prio_char", {4'h0, red, green, blue}, 16'h0B0F);
        repeat (3) step(4'h3, 8'h25, 1, 1);
        chk("prio_obj", {4'h0, red, green, blue}, 16'h00F0);

        // latency and hold with alternating char pixels
        for (int i = 0; i < 12; i++) step(4'h0, (i % 2) ? 8'h25 : 8'($urandom), 1, 1);

        // horizontal blank for 16 ticks with an opaque object
        for (int i = 0; i < 16; i++) step(4'h3, 8'h25, 0, 1);
        for (int i = 0; i < 6; i++) step(4'h0, 8'h25, 1, 1);
        step(4'h0, 8'h25, 1, 0);
        for (int i = 0; i < 4; i++) step(4'h0, 8'h25, 1, 1);

        // reset mid-frame
        chk("pre_rst", {4'h0, red, green, blue}, 16'h0B0F);
        @(negedge clk);
        rst = 1;
        #1;
        chk("rst_async", {2'b00, red, green, blue, LHBL_dly, LVBL_dly}, 16'h0);
        repeat (3) @(negedge clk);
        rst = 0;
        nt = 0;
        step(4'h0, 8'h25, 1, 1);
        step(4'h0, 8'h25, 1, 1);
        chk("rst_tick2", {4'h0, red, green, blue}, 16'h0000);
        step(4'h0, 8'h25, 1, 1);
        chk("rst_tick3", {4'h0, red, green, blue}, 16'h0B0F);

        // download while running
        prog(9'h107, 8'h00);
        repeat (3) step(4'h0, 8'h25, 1, 1);
        chk("dl_pal", {4'h0, red, green, blue}, 16'h0000);
        prog(9'h150, 8'hFF);
        prog(9'h1E5, 8'hFF);
        for (int i = 0; i < 4; i++) step(4'h0, 8'h50, 1, 1);
        for (int i = 0; i < 4; i++) step(4'h0, 8'h45, 1, 1);
        prog(9'h107, 8'hC5);

        // random pixels with occasional downloads
        for (int i = 0; i < 250; i++) begin
            step(($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                 8'($urandom),
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 19) != 0);
            if ($urandom_range(0, 4) == 0) prog(9'($urandom), 8'($urandom));
        end

`ifdef KICKER_LAYER_MASK_EN
        prog(9'h025, 8'h07);
        prog(9'h107, 8'hC5);
        prog(9'h100, 8'h5A);
        gfx = 2'b01;
        repeat (3) step(4'h3, 8'h25, 1, 1);
        chk("mask_char_only", {4'h0, red, green, blue}, 16'h0B0F);
        gfx = 2'b00;
        repeat (3) step(4'h3, 8'h25, 1, 1);
        chk("mask_none", {4'h0, red, green, blue}, 16'h0465);
        gfx = 2'b10;
        for (int i = 0; i < 30; i++) step(4'($urandom), 8'($urandom), 1, 1);
        gfx = 2'b11;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
